// File: rtl/imem_pkg.sv
// Shared imem geometry and the loader's FSM state encoding.
// Loader files import this package; it holds no logic.
package imem_pkg;

    localparam int IMEM_ADDR_W = 13;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/imem_word_asm.sv
// Byte lane packer: drops stream bytes into a 32-bit little-endian word and tracks lane enables.
// Latency: byte visible on o_word_dat the cycle after i_wr_en; clear wins over a write.
// Backpressure: none, the parent only writes when it has accepted a byte.
module imem_word_asm (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [1:0]  i_lane,
    input  logic [7:0]  i_byte_dat,
    input  logic        i_clear,
    output logic [31:0] o_word_dat,
    output logic [3:0]  o_word_mask
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_word_dat  <= '0;
            o_word_mask <= '0;
        end else if (i_clear) begin
            o_word_dat  <= '0;
            o_word_mask <= '0;
        end else if (i_wr_en) begin
            o_word_dat[8*i_lane +: 8] <= i_byte_dat;
            o_word_mask[i_lane]       <= 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream into 32-bit imem word writes and stalls core fetch while loading (IMEM_LOADER_CSUM_EN adds a trailing checksum byte).
// Latency: word write one cycle after its completing byte; best case 4 bytes per 5 cycles.
// Backpressure: o_byte_ready only in RECV (and CHECK); the imem write port never stalls.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic [7:0]        i_byte_data,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_core_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // Largest payload that still fits between BASE_ADDR and the top of imem.
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

    loader_state_e     state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              byte_acc;
    logic              word_last;
    logic [1:0]        lane;
    logic [31:0]       word_dat;
    logic [3:0]        word_mask;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        csum_q;
`endif

    assign lane      = count_q[1:0];
    assign count_inc = count_q + (ADDR_W+1)'(1);
    assign byte_acc  = i_byte_valid & o_byte_ready;
    assign word_last = (lane == 2'd3) || (count_inc == len_q);

`ifdef IMEM_LOADER_CSUM_EN
    assign o_byte_ready = (state_q == RECV) || (state_q == CHECK);
`else
    assign o_byte_ready = (state_q == RECV);
`endif

    imem_word_asm u_word_asm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (byte_acc && (state_q == RECV)),
        .i_lane      (lane),
        .i_byte_dat  (i_byte_data),
        .i_clear     (state_q == WRITE),
        .o_word_dat  (word_dat),
        .o_word_mask (word_mask)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        len_q   <= i_len;
                        addr_q  <= ADDR_W'(BASE_ADDR);
                        count_q <= '0;
                        err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q  <= '0;
`endif
                        if (i_len == '0) begin
                            state_q <= DONE;
                        end else if (i_len > MAX_LEN) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (byte_acc) begin
                        count_q <= count_inc;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q  <= csum_q + i_byte_data;
`endif
                        if (word_last) begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    addr_q <= addr_q + ADDR_W'(4);
                    if (count_q < len_q) begin
                        state_q <= RECV;
                    end else begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_q <= CHECK;
`else
                        state_q <= DONE;
`endif
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                CHECK: begin
                    if (byte_acc) begin
                        if (i_byte_data != csum_q) begin
                            err_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_we     = (state_q == WRITE);
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = word_dat;
    assign o_mem_bmask  = word_mask;
    assign o_core_stall = (state_q != IDLE);
    assign o_busy       = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
    assign o_done       = (state_q == DONE);
    assign o_err        = err_q;

endmodule
